// File: rtl/mem_arb_if.sv
// Bundle of the fetch, load/store and memory-port signals seen by mem_arb.
// slave is the arbiter's view; master is the core-plus-memory side.
interface mem_arb_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic        bus_err;
  logic        busy;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata,
    output bus_err, busy
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata,
    input  bus_err, busy
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin IFU/LSU arbiter onto one memory port, one transaction in flight.
// Grant-to-mem_reqValid 1 cycle, response returned 1 cycle after mem_respValid; requesters hold reqValid until respValid.
module mem_arb #(
  parameter int TIMEOUT = 256,
  parameter int CW      = 9
) (
  input  logic      clock,
  input  logic      reset,
  mem_arb_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic          r_wen;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic [31:0]   r_ifu_rdata;
  logic [31:0]   r_lsu_rdata;

  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_timeout;

  // On a tie the requester that did not win last time is granted.
  assign w_grant_ifu = bus.ifu_reqValid && (!bus.lsu_reqValid || (r_last == OWN_LSU));
  assign w_grant_lsu = bus.lsu_reqValid && (!bus.ifu_reqValid || (r_last == OWN_IFU));
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_IFU;
      r_last      <= OWN_LSU;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsu) begin
            r_owner <= OWN_LSU;
            r_last  <= OWN_LSU;
            r_addr  <= bus.lsu_addr;
            r_size  <= bus.lsu_size;
            r_wen   <= bus.lsu_wen;
            r_wdata <= bus.lsu_wdata;
            r_wmask <= bus.lsu_wmask;
            r_state <= S_REQ;
          end else if (w_grant_ifu) begin
            r_owner <= OWN_IFU;
            r_last  <= OWN_IFU;
            r_addr  <= bus.ifu_addr;
            r_size  <= 2'b10;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (bus.mem_respValid) begin
            if (r_owner == OWN_LSU) r_lsu_rdata <= bus.mem_rdata;
            else                    r_ifu_rdata <= bus.mem_rdata;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            if (r_owner == OWN_LSU) r_lsu_rdata <= '0;
            else                    r_ifu_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_reqValid  = (r_state == S_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_size      = r_size;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wmask     = r_wmask;
  assign bus.ifu_respValid = (r_state == S_RESP) && (r_owner == OWN_IFU);
  assign bus.lsu_respValid = (r_state == S_RESP) && (r_owner == OWN_LSU);
  assign bus.ifu_rdata     = r_ifu_rdata;
  assign bus.lsu_rdata     = r_lsu_rdata;
  assign bus.bus_err       = (r_state == S_RESP) && r_err;
  assign bus.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: stimulus pushes expected grants/responses into queues,
// independent monitors pop and compare whenever the DUT presents mem_reqValid or respValid.
module tb_mem_arb;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } memreq_t;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    int          delay;  // mem_respValid this many cycles after mem_reqValid; <0 never
    logic [31:0] data;
    int          done;   // requester respValid this many cycles after mem_reqValid; 0 none
  } plan_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  memreq_t     exp_mem[$];
  resp_t       exp_resp[$];
  int          exp_cyc[$];
  plan_t       plans[$];
  logic [31:0] ifu_q[$];
  memreq_t     lsu_q[$];

  mem_arb_if bus();

  mem_arb #(.TIMEOUT(4), .CW(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [159:0] all_outputs();
    return {bus.mem_reqValid, bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wdata,
            bus.mem_wmask, bus.ifu_respValid, bus.ifu_rdata, bus.lsu_respValid,
            bus.lsu_rdata, bus.bus_err, bus.busy};
  endfunction

  // Requesters: hold the head request until its respValid, updating at negedge.
  initial begin
    bus.ifu_reqValid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_reqValid = 1'b0; bus.lsu_addr = '0; bus.lsu_size = '0;
    bus.lsu_wen = 1'b0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    forever begin
      @(negedge clock);
      if (bus.ifu_respValid && ifu_q.size() > 0) void'(ifu_q.pop_front());
      if (bus.lsu_respValid && lsu_q.size() > 0) void'(lsu_q.pop_front());
      bus.ifu_reqValid = (ifu_q.size() > 0);
      if (ifu_q.size() > 0) bus.ifu_addr = ifu_q[0];
      bus.lsu_reqValid = (lsu_q.size() > 0);
      if (lsu_q.size() > 0) begin
        bus.lsu_addr  = lsu_q[0].addr;
        bus.lsu_size  = lsu_q[0].size;
        bus.lsu_wen   = lsu_q[0].wen;
        bus.lsu_wdata = lsu_q[0].wdata;
        bus.lsu_wmask = lsu_q[0].wmask;
      end
    end
  end

  // Memory: answers each request according to the next plan entry.
  initial begin
    plan_t p;
    int r;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_reqValid && plans.size() > 0) begin
        r = cyc;
        p = plans.pop_front();
        if (p.done > 0) exp_cyc.push_back(r + p.done);
        if (p.delay >= 0) begin
          repeat (p.delay) @(posedge clock);
          #1;
          bus.mem_respValid = 1'b1;
          bus.mem_rdata     = p.data;
          @(posedge clock);
          #1;
          bus.mem_respValid = 1'b0;
          bus.mem_rdata     = '0;
        end
      end
    end
  end

  // Memory-side monitor: request contents and stability while busy.
  initial begin
    memreq_t cur;
    memreq_t snap;
    logic    have_snap;
    have_snap = 1'b0;
    snap = '0;
    forever begin
      @(negedge clock);
      cur = '{bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
      if (bus.mem_reqValid) begin
        if (exp_mem.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL mem_req_unexpected: got %0h, want no request (cycle %0d)", cur, cyc);
        end else begin
          chk("mem_req_fields", cur, exp_mem.pop_front());
        end
        snap = cur;
        have_snap = 1'b1;
      end else if (bus.busy && have_snap) begin
        chk("mem_fields_stable", cur, snap);
      end else if (!bus.busy) begin
        have_snap = 1'b0;
      end
    end
  end

  // Response monitor: owner, data, bus_err and cycle of every respValid.
  initial begin
    resp_t got;
    forever begin
      @(negedge clock);
      if (bus.ifu_respValid || bus.lsu_respValid) begin
        got.lsu  = bus.lsu_respValid;
        got.data = bus.lsu_respValid ? bus.lsu_rdata : bus.ifu_rdata;
        got.err  = bus.bus_err;
        chk("resp_one_owner", {bus.ifu_respValid, bus.lsu_respValid} == 2'b11, 1'b0);
        if (exp_resp.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL resp_unexpected: got %0h, want no response (cycle %0d)", got, cyc);
        end else begin
          chk("resp_value", got, exp_resp.pop_front());
          if (exp_cyc.size() > 0) chk("resp_cycle", cyc, exp_cyc.pop_front());
        end
      end else if (bus.bus_err) begin
        chk("bus_err_alone", bus.bus_err, 1'b0);
      end
    end
  end

  task automatic issue_ifu(input logic [31:0] a, input int dly, input logic [31:0] d,
                           input int done, input logic err);
    ifu_q.push_back(a);
    exp_mem.push_back(memreq_t'{a, 2'b10, 1'b0, 32'h0, 4'h0});
    plans.push_back('{dly, d, done});
    if (done > 0) exp_resp.push_back(resp_t'{1'b0, err ? 32'h0 : d, err});
  endtask

  task automatic issue_lsu(input memreq_t m, input int dly, input logic [31:0] d,
                           input int done, input logic err);
    lsu_q.push_back(m);
    exp_mem.push_back(m);
    plans.push_back('{dly, d, done});
    if (done > 0) exp_resp.push_back(resp_t'{1'b1, err ? 32'h0 : d, err});
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((ifu_q.size() != 0 || lsu_q.size() != 0 || exp_resp.size() != 0) && n < maxc) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_in_time", n < maxc, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("grants_all_seen", exp_mem.size(), 0);
    chk("idle_after_drain", bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", all_outputs(), '0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_no_request", all_outputs(), '0);

    // IFU-only read, memory answers 2 cycles after the request.
    issue_ifu(32'h8000_0000, 2, 32'h0000_0013, 3, 1'b0);
    drain(40);

    // Tie after reset: IFU, LSU, IFU, LSU with both held.
    do_reset();
    issue_ifu(32'h8000_0004, 1, 32'h1111_0001, 2, 1'b0);
    issue_lsu('{32'h2000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 4'h0}, 2, 32'h2222_0002, 3, 1'b0);
    issue_ifu(32'h8000_0008, 1, 32'h1111_0003, 2, 1'b0);
    issue_lsu('{32'h2000_0008, 2'b01, 1'b0, 32'h0, 4'h0}, 3, 32'h2222_0004, 4, 1'b0);
    drain(100);

    // LSU byte store.
    issue_lsu('{32'h1000_0002, 2'b00, 1'b1, 32'h00AB_0000, 4'b0100}, 3, 32'hCAFE_0000, 4, 1'b0);
    drain(40);

    // Timeout with no response, then timeout followed by a late response.
    issue_ifu(32'h8000_0100, -1, 32'h0, 5, 1'b1);
    drain(40);
    issue_ifu(32'h8000_0104, 7, 32'hBAD0_0BAD, 5, 1'b1);
    drain(40);
    repeat (2) @(posedge clock);
    #1;
    chk("late_resp_ignored", {bus.busy, bus.ifu_rdata}, 33'h0);

    // Response on the exact timeout cycle wins.
    issue_lsu('{32'h3000_0000, 2'b10, 1'b0, 32'h0, 4'h0}, 4, 32'h5555_AAAA, 5, 1'b0);
    drain(40);

    // Reset during WAIT abandons the IFU transaction.
    issue_ifu(32'h8000_0200, 3, 32'h0000_0077, 0, 1'b0);
    n = 0;
    while (!bus.mem_reqValid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("midwait_req_seen", n < 20, 1'b1);
    @(posedge clock);
    #1;
    chk("midwait_busy", bus.busy, 1'b1);
    ifu_q.delete();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("midwait_reset_outputs", all_outputs(), '0);
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_resp_ignored", all_outputs(), '0);
    issue_ifu(32'h8000_0300, 1, 32'h3300_0001, 2, 1'b0);
    issue_lsu('{32'h4000_0000, 2'b10, 1'b0, 32'h0, 4'h0}, 1, 32'h4400_0002, 2, 1'b0);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-master memory arbiter between the core and its single memory port. It accepts independent fetch (IFU) and load/store (LSU) requests in the cpu's reqValid/respValid handshake and serializes them onto one downstream port. Arbitration is round-robin and only one transaction is outstanding at a time. The requester's fields are latched into the arbiter, and the memory response is routed back to the owning requester. An optional timeout turns a hung memory access into an error response, so the core's state machine cannot deadlock.

## Interface
Parameters:
- TIMEOUT, default 256: number of WAIT cycles before an error response is forced; 0 disables the timeout.
- CW, default 9: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  in  1  Single clock; all state changes on the rising edge.
- reset  in  1  Synchronous, active-low (0 = reset).
- ifu_reqValid  in  1  Fetch request; held high with a stable ifu_addr until ifu_respValid.
- ifu_addr  in  32  Fetch address.
- ifu_respValid  out  1  One-cycle pulse; ifu_rdata is valid in that cycle.
- ifu_rdata  out  32  Fetch data.
- lsu_reqValid  in  1  Load/store request; held high with all fields stable until lsu_respValid.
- lsu_addr  in  32  Load/store address.
- lsu_size  in  2  Access size.
- lsu_wen  in  1  Write enable.
- lsu_wdata  in  32  Write data.
- lsu_wmask  in  4  Byte write mask.
- lsu_respValid  out  1  One-cycle pulse.
- lsu_rdata  out  32  Load data.
- mem_reqValid  out  1  One-cycle request pulse to memory.
- mem_addr  out  32  Memory address.
- mem_size  out  2  Memory access size.
- mem_wen  out  1  Memory write enable.
- mem_wdata  out  32  Memory write data.
- mem_wmask  out  4  Memory byte write mask.
- mem_respValid  in  1  Memory response pulse.
- mem_rdata  in  32  Memory read data.
- bus_err  out  1  One-cycle pulse, coincident with a timed-out response.
- busy  out  1  High whenever state is not IDLE.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- Owner register: `owner` (IFU or LSU).
- Round-robin register: `last`, reset value LSU, so IFU wins the first tie.
- IDLE:
  - Samples both reqValid inputs.
  - If only one is high, grant it. If both are high, grant the one that is not `last`.
  - On grant: latch addr/size/wen/wdata/wmask into the mem_* registers. IFU grants force size=2'b10, wen=0, wmask=4'b0000, wdata=0.
  - On grant: set `owner`, set `last` to the granted requester, go to REQ.
  - With no request, stay in IDLE.
- REQ:
  - mem_reqValid=1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
  - A mem_respValid arriving in this cycle is ignored.
- WAIT:
  - mem_reqValid=0; mem_* fields stay stable.
  - On mem_respValid: register mem_rdata into the owner's rdata, go to RESP with err=0.
  - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1: set rdata=0, err=1, go to RESP.
  - Otherwise increment the counter; it saturates and never wraps.
  - If mem_respValid and the timeout arrive in the same cycle, the response wins and err=0.
- RESP:
  - The owner's respValid=1 for one cycle.
  - bus_err equals the latched err.
  - The non-owner's respValid stays 0.
  - Go to IDLE.
- rdata outputs hold their last value between responses.
- mem_respValid in IDLE, REQ, or RESP is ignored; it has no side effects.
- Requesters derive reqValid from registered state. The reqValid seen in IDLE, the cycle after RESP, is therefore treated as a new request.
- Reset (reset=0 at a clock edge), from any state:
  - state=IDLE, last=LSU, counter=0, err=0.
  - All outputs become 0, including rdata and the mem_* fields.
  - An in-flight transaction is abandoned and no respValid is produced for it.
  - A memory response that arrives after reset is ignored.

## Timing
- Request first sampled high in IDLE at cycle N:
  - mem_reqValid=1 at N+1.
  - WAIT begins at N+2.
  - mem_respValid at cycle M ≥ N+2 gives requester respValid at M+1.
- Minimum transaction is 4 cycles (IDLE, REQ, WAIT, RESP), so one transaction completes per 4 cycles at most.
- Back-to-back is possible: a new grant can occur in the IDLE cycle at M+2.
- Timeout case: entering WAIT at cycle W, respValid and bus_err pulse at W+TIMEOUT.
- busy rises at N+1 and falls in the cycle after RESP.
- There are no combinational paths from inputs to outputs; every output is registered or decoded from state.

## Test plan
- IFU-only read:
  - Stimulus: ifu_reqValid with addr 0x8000_0000; memory responds 2 cycles after mem_reqValid with 0x0000_0013.
  - Required: mem_reqValid is one cycle with size=2, wen=0.
  - Required: ifu_respValid pulses once with 0x0000_0013; lsu_respValid stays 0.
- Simultaneous requests after reset:
  - Stimulus: IFU and LSU both request.
  - Required: IFU is served first, then LSU; with both held, grants alternate IFU, LSU, IFU.
- LSU store:
  - Stimulus: addr 0x1000_0002, wdata 0x00AB_0000, wmask 4'b0100, wen=1.
  - Required: identical values appear on mem_* during REQ and stay stable through WAIT; lsu_respValid follows mem_respValid by 1 cycle.
- Timeout:
  - Stimulus: TIMEOUT=4; memory never responds.
  - Required: respValid and bus_err pulse together 4 cycles after WAIT entry with rdata=0, and the arbiter returns to IDLE.
  - Stimulus: a late mem_respValid arrives afterwards. Required: it is ignored.
- Collision: mem_respValid arrives on the exact timeout cycle. Required: data is delivered and bus_err=0.
- Reset mid-WAIT:
  - Stimulus: assert reset=0 for one cycle during WAIT, then deliver mem_respValid.
  - Required: no respValid, all outputs 0, busy=0, and the next IFU+LSU tie is granted to IFU.
